// File: rtl/display_8x8_capture.sv
// display_8x8_capture
//   Receive-side model of the 8x8 RGB LED display serial interface. It watches
//   the shift-register control lines the display driver produces, rebuilds each
//   latched column, streams that column out over valid/ready, and keeps an
//   8-column RGB frame buffer that can be read back.
//
// Ports
//   clk, rst_n        system clock; synchronous active-low reset
//   reset_out         shift-register reset from the driver (active low)
//   OE                output enable (active low); observed only
//   SH_CP, ST_CP, DS  shift clock, store clock, serial data (all sync to clk)
//   col_select[7:0]   active column, one-hot, active high
//   col_valid/ready   column stream handshake
//   col_idx, red_out, green_out, blue_out   captured column payload
//   rd_col, rd_red, rd_green, rd_blue       registered frame-buffer read port
//   frame_done        1-cycle pulse once all 8 columns have been stored
//   err_len, err_col, overrun               sticky error flags
//
// Handshake: col_valid rises with a new column and then holds, together with
// col_idx/red_out/green_out/blue_out, until col_valid && col_ready at a posedge.
// A latch in that same accepting cycle reloads the payload (back-to-back valid).
module display_8x8_capture #(
  parameter int BITS_PER_COL  = 24,
  parameter bit DS_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reset_out,
  input  logic       OE,
  input  logic       SH_CP,
  input  logic       ST_CP,
  input  logic       DS,
  input  logic [7:0] col_select,
  output logic       col_valid,
  input  logic       col_ready,
  output logic [2:0] col_idx,
  output logic [7:0] red_out,
  output logic [7:0] green_out,
  output logic [7:0] blue_out,
  input  logic [2:0] rd_col,
  output logic [7:0] rd_red,
  output logic [7:0] rd_green,
  output logic [7:0] rd_blue,
  output logic       frame_done,
  output logic       err_len,
  output logic       err_col,
  output logic       overrun
);

  localparam logic [4:0] LEN = 5'(BITS_PER_COL);

  // OE does not gate capture; it is only part of the snooped bus.
  logic oe_unused;
  assign oe_unused = OE;

  logic        sh_prev_q, st_prev_q;
  logic [23:0] sreg_q, sreg_d, sreg_s;
  logic [4:0]  cnt_q, cnt_d, cnt_s;
  logic [7:0]  mask_q, mask_d, mask_n;
  logic        col_valid_q, col_valid_d;
  logic [2:0]  col_idx_q, col_idx_d;
  logic [23:0] col_data_q, col_data_d;
  logic        frame_done_q, frame_done_d;
  logic        err_len_q, err_len_d;
  logic        err_col_q, err_col_d;
  logic        overrun_q, overrun_d;
  logic [23:0] fb_q [8];
  logic [23:0] rd_q;

  logic       sh_rise, st_rise;
  logic       sel_onehot;
  logic [2:0] sel_idx;
  logic       fb_we;

  always_comb begin
    sh_rise = SH_CP & ~sh_prev_q;
    st_rise = ST_CP & ~st_prev_q;

    // Shift stage first; a latch in the same cycle sees the updated values.
    sreg_s = sreg_q;
    cnt_s  = cnt_q;
    if (!reset_out) begin
      sreg_s = '0;
      cnt_s  = '0;
    end else if (sh_rise) begin
      sreg_s = {sreg_q[22:0], DS ^ DS_ACTIVE_LOW};
      cnt_s  = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
    end

    sel_onehot = (col_select != 8'd0) && ((col_select & (col_select - 8'd1)) == 8'd0);
    sel_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (col_select[i]) sel_idx = 3'(i);
    end

    sreg_d       = sreg_s;
    cnt_d        = cnt_s;
    mask_d       = mask_q;
    mask_n       = mask_q | (8'd1 << sel_idx);
    col_valid_d  = col_valid_q;
    col_idx_d    = col_idx_q;
    col_data_d   = col_data_q;
    frame_done_d = 1'b0;
    err_len_d    = err_len_q;
    err_col_d    = err_col_q;
    overrun_d    = overrun_q;
    fb_we        = 1'b0;

    if (col_valid_q && col_ready) col_valid_d = 1'b0;

    if (st_rise) begin
      cnt_d = '0;
      if (cnt_s != LEN) err_len_d = 1'b1;
      if (!sel_onehot) begin
        err_col_d = 1'b1;
      end else begin
        fb_we = 1'b1;
        if (mask_n == 8'hFF) begin
          frame_done_d = 1'b1;
          mask_d       = 8'h00;
        end else begin
          mask_d = mask_n;
        end
        if (!col_valid_q || col_ready) begin
          col_valid_d = 1'b1;
          col_idx_d   = sel_idx;
          col_data_d  = sreg_s;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_prev_q    <= 1'b0;
      st_prev_q    <= 1'b0;
      sreg_q       <= '0;
      cnt_q        <= '0;
      mask_q       <= '0;
      col_valid_q  <= 1'b0;
      col_idx_q    <= '0;
      col_data_q   <= '0;
      frame_done_q <= 1'b0;
      err_len_q    <= 1'b0;
      err_col_q    <= 1'b0;
      overrun_q    <= 1'b0;
      rd_q         <= '0;
      for (int i = 0; i < 8; i++) fb_q[i] <= '0;
    end else begin
      sh_prev_q    <= SH_CP;
      st_prev_q    <= ST_CP;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      col_valid_q  <= col_valid_d;
      col_idx_q    <= col_idx_d;
      col_data_q   <= col_data_d;
      frame_done_q <= frame_done_d;
      err_len_q    <= err_len_d;
      err_col_q    <= err_col_d;
      overrun_q    <= overrun_d;
      // Read samples the pre-write contents: same-cycle write returns old data.
      rd_q         <= fb_q[rd_col];
      if (fb_we) fb_q[sel_idx] <= sreg_s;
    end
  end

  assign col_valid  = col_valid_q;
  assign col_idx    = col_idx_q;
  assign red_out    = col_data_q[23:16];
  assign green_out  = col_data_q[15:8];
  assign blue_out   = col_data_q[7:0];
  assign rd_red     = rd_q[23:16];
  assign rd_green   = rd_q[15:8];
  assign rd_blue    = rd_q[7:0];
  assign frame_done = frame_done_q;
  assign err_len    = err_len_q;
  assign err_col    = err_col_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_display_8x8_capture.sv
module tb_display_8x8_capture;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       reset_out = 1'b1;
  logic       oe = 1'b0;
  logic       sh_cp = 1'b0;
  logic       st_cp = 1'b0;
  logic       ds = 1'b0;
  logic [7:0] col_select = 8'h00;
  logic       col_ready = 1'b1;
  logic [2:0] rd_col = 3'd0;

  logic       col_valid, frame_done, err_len, err_col, overrun;
  logic [2:0] col_idx;
  logic [7:0] red_out, green_out, blue_out, rd_red, rd_green, rd_blue;

  logic       col_valid2, frame_done2, err_len2, err_col2, overrun2;
  logic [2:0] col_idx2;
  logic [7:0] red_out2, green_out2, blue_out2, rd_red2, rd_green2, rd_blue2;

  display_8x8_capture #(.BITS_PER_COL(24), .DS_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .reset_out(reset_out), .OE(oe), .SH_CP(sh_cp),
    .ST_CP(st_cp), .DS(ds), .col_select(col_select), .col_valid(col_valid),
    .col_ready(col_ready), .col_idx(col_idx), .red_out(red_out),
    .green_out(green_out), .blue_out(blue_out), .rd_col(rd_col), .rd_red(rd_red),
    .rd_green(rd_green), .rd_blue(rd_blue), .frame_done(frame_done),
    .err_len(err_len), .err_col(err_col), .overrun(overrun)
  );

  display_8x8_capture #(.BITS_PER_COL(24), .DS_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .reset_out(reset_out), .OE(oe), .SH_CP(sh_cp),
    .ST_CP(st_cp), .DS(ds), .col_select(col_select), .col_valid(col_valid2),
    .col_ready(col_ready), .col_idx(col_idx2), .red_out(red_out2),
    .green_out(green_out2), .blue_out(blue_out2), .rd_col(rd_col), .rd_red(rd_red2),
    .rd_green(rd_green2), .rd_blue(rd_blue2), .frame_done(frame_done2),
    .err_len(err_len2), .err_col(err_col2), .overrun(overrun2)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int fd_cnt = 0;

  always @(posedge clk) if (frame_done) fd_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    ds = b;
    sh_cp = 1'b1;
    tick();
    sh_cp = 1'b0;
    tick();
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
  endtask

  // Raise ST_CP for one cycle; outputs are sampled right after that edge.
  task automatic latch(input logic [7:0] sel);
    col_select = sel;
    st_cp = 1'b1;
    tick();
    st_cp = 1'b0;
  endtask

  task automatic read_fb(input logic [2:0] c);
    rd_col = c;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] exp_red, exp_grn, exp_blu;

  initial begin
    do_reset();
    check_eq("rst_col_valid", col_valid, 0);
    check_eq("rst_red_out", red_out, 0);
    check_eq("rst_flags", {frame_done, err_len, err_col, overrun}, 0);
    check_eq("rst_rd_red", rd_red, 0);

    // Single column: R=80 G=00 B=01 into column 0.
    send_bits(24'h800001, 24);
    latch(8'h01);
    check_eq("c0_valid", col_valid, 1);
    check_eq("c0_idx", col_idx, 0);
    check_eq("c0_rgb", {red_out, green_out, blue_out}, 24'h800001);
    tick();
    check_eq("c0_valid_drop", col_valid, 0);
    read_fb(3'd0);
    check_eq("c0_rd", {rd_red, rd_green, rd_blue}, 24'h800001);

    // Diagonal frame, columns 0..7.
    fd_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      exp_red = 8'h80 >> k;
      exp_grn = 8'(k);
      exp_blu = 8'h01 << k;
      send_bits({8'h00, exp_red, exp_grn, exp_blu}, 24);
      latch(8'h01 << k);
      check_eq($sformatf("diag_out%0d", k), {5'd0, col_idx, red_out, green_out, blue_out},
               {5'd0, 3'(k), exp_red, exp_grn, exp_blu});
      tick();
      if (k == 6) check_eq("diag_no_early_done", fd_cnt, 0);
    end
    tick();
    check_eq("diag_frame_done", fd_cnt, 1);
    for (int k = 0; k < 8; k++) begin
      exp_red = 8'h80 >> k;
      read_fb(3'(k));
      check_eq($sformatf("diag_rd%0d", k), rd_red, exp_red);
    end
    check_eq("diag_no_err", {err_len, err_col, overrun}, 0);

    // Length errors: short column, then long column keeps last 24 bits.
    send_bits(32'h000ABCDE, 20);
    latch(8'h04);
    check_eq("short_err_len", err_len, 1);
    tick();
    send_bits(32'h3F123456, 30);
    latch(8'h08);
    check_eq("long_rgb", {red_out, green_out, blue_out}, 24'h123456);
    check_eq("long_err_len", err_len, 1);
    tick();
    read_fb(3'd3);
    check_eq("long_rd", rd_red, 8'h12);

    // Column-select errors: nothing stored or emitted.
    send_bits(24'hFFFFFF, 24);
    latch(8'h03);
    check_eq("sel03_valid", col_valid, 0);
    check_eq("sel03_err_col", err_col, 1);
    tick();
    latch(8'h00);
    check_eq("sel00_valid", col_valid, 0);
    tick();
    read_fb(3'd0);
    check_eq("sel_buf0", rd_red, 8'h80);
    read_fb(3'd1);
    check_eq("sel_buf1", rd_red, 8'h40);

    // Overrun: consumer stalls across two latches.
    col_ready = 1'b0;
    send_bits(24'hA1B2C3, 24);
    latch(8'h20);
    check_eq("ovr_first_valid", col_valid, 1);
    tick();
    send_bits(24'h0F0E0D, 24);
    latch(8'h40);
    check_eq("ovr_flag", overrun, 1);
    check_eq("ovr_hold", {5'd0, col_idx, red_out, green_out, blue_out}, {5'd0, 3'd5, 24'hA1B2C3});
    check_eq("ovr_valid", col_valid, 1);
    tick();
    read_fb(3'd6);
    check_eq("ovr_buf6", {rd_red, rd_green, rd_blue}, 24'h0F0E0D);
    col_ready = 1'b1;
    tick();
    check_eq("ovr_accept", col_valid, 0);

    // rst_n clears sticky flags; a partial column is then aborted by reset_out.
    do_reset();
    check_eq("rst2_flags", {err_len, err_col, overrun}, 0);
    send_bits(32'h000003FF, 10);
    reset_out = 1'b0;
    tick();
    reset_out = 1'b1;
    tick();
    send_bits(24'h5A3C96, 24);
    latch(8'h80);
    check_eq("rso_rgb", {red_out, green_out, blue_out}, 24'h5A3C96);
    check_eq("rso_idx", col_idx, 7);
    check_eq("rso_err_len", err_len, 0);
    tick();

    // All-zero DS stream: normal polarity gives 00, active-low gives FF.
    send_bits(24'h000000, 24);
    latch(8'h01);
    check_eq("al0_rgb", {red_out, green_out, blue_out}, 24'h000000);
    check_eq("al1_rgb", {red_out2, green_out2, blue_out2}, 24'hFFFFFF);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
